mem_port_arbiter: RTL and testbench

- Shares the single data port of the main memory between two requesters: M0 = core load/store path (higher default priority), M1 = DMA/debug loader.
- Arbitrates round-robin and latches one command at a time.
- Generates byte enables, detects misalignment, and extracts and sign-/zero-extends load data.
- Returns a single-cycle response to the winning requester.
- Sits between the core/DMA and the memory's REQ/GNT/VALID/ERR data interface. The instruction port is untouched.

---
 rtl/mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the main memory data port between two requesters: M0 (core
//   load/store path) and M1 (DMA/debug loader). One command is latched at
//   a time. Byte enables and alignment are derived from SIZE/AD, and load
//   data is extracted from the aligned word and sign/zero extended.
//   Every outcome is a single-cycle pulse to the requester that won.
//
// Ports
//   CLK, RESET_N         clock, synchronous active-low reset
//   REQx/WEx/SIZEx/UNSx  request, store flag, size (00 b, 01 h, 10 w),
//   ADx/WDx              zero-extend flag, byte address, store data
//   GNTx                 command accepted (one cycle)
//   VALIDx/ERRx/RDx      completion OK / failed, extended load data
//   MREQ/MWE/MBYTES/     memory request, write enable, byte enables,
//   MAD/MWD              address, right-justified write data
//   MGNT/MVALID/MERR/MRD memory accept, completion, error, read word
//
// Timing
//   All outputs are registered. GNT appears the cycle after the pick;
//   a command rejected up front (bad size/alignment) shows GNT and ERR
//   together in that same cycle. WAIT gives up after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [1:0]        SIZE0,
    input  logic [1:0]        SIZE1,
    input  logic              UNS0,
    input  logic              UNS1,
    input  logic [ADDR_W-1:0] AD0,
    input  logic [ADDR_W-1:0] AD1,
    input  logic [31:0]       WD0,
    input  logic [31:0]       WD1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              VALID0,
    output logic              VALID1,
    output logic              ERR0,
    output logic              ERR1,
    output logic [31:0]       RD0,
    output logic [31:0]       RD1,
    output logic              MREQ,
    output logic              MWE,
    output logic [3:0]        MBYTES,
    output logic [ADDR_W-1:0] MAD,
    output logic [31:0]       MWD,
    input  logic              MGNT,
    input  logic              MVALID,
    input  logic              MERR,
    input  logic [31:0]       MRD
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // only the fields needed after the pick to shape the response;
    // address and store data live in the memory-side registers
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] a;
    } cmd_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t            state_q, state_n;
    logic              rr_q, rr_n;
    logic              owner_q, owner_n;
    cmd_t              cmd_q, cmd_n, cmd_in;
    logic [7:0]        cnt_q, cnt_n;
    logic [1:0]        gnt_q, gnt_n, vld_q, vld_n, err_q, err_n;
    logic [31:0]       rd0_q, rd0_n, rd1_q, rd1_n;
    logic              mreq_q, mreq_n, mwe_q, mwe_n;
    logic [3:0]        mbytes_q, mbytes_n;
    logic [ADDR_W-1:0] mad_q, mad_n, ad_in;
    logic [31:0]       mwd_q, mwd_n, wd_in;
    logic              sel1;
    logic              done, done_err;
    logic [31:0]       done_rd;

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            2'b10:   return a == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] bytes_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] a);
        logic [31:0] lane;
        lane = word >> {a, 3'b000};
        case (size)
            2'b00:   return {{24{~uns & lane[7]}}, lane[7:0]};
            2'b01:   return {{16{~uns & lane[15]}}, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    // Requester select: a lone request wins; on a tie the requester that
    // did not win last time goes (rr_q resets to 1 so M0 takes the first tie).
    always_comb begin
        sel1        = REQ1 & (~REQ0 | ~rr_q);
        cmd_in.we   = sel1 ? WE1   : WE0;
        cmd_in.size = sel1 ? SIZE1 : SIZE0;
        cmd_in.uns  = sel1 ? UNS1  : UNS0;
        ad_in       = sel1 ? AD1   : AD0;
        wd_in       = sel1 ? WD1   : WD0;
        cmd_in.a    = ad_in[1:0];
    end

    always_comb begin
        state_n  = state_q;
        rr_n     = rr_q;
        owner_n  = owner_q;
        cmd_n    = cmd_q;
        cnt_n    = cnt_q;
        gnt_n    = 2'b00;
        vld_n    = 2'b00;
        err_n    = 2'b00;
        rd0_n    = rd0_q;
        rd1_n    = rd1_q;
        mreq_n   = mreq_q;
        mwe_n    = mwe_q;
        mbytes_n = mbytes_q;
        mad_n    = mad_q;
        mwd_n    = mwd_q;
        done     = 1'b0;
        done_err = 1'b0;
        done_rd  = '0;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (REQ0 | REQ1) begin
                    owner_n = sel1;
                    rr_n    = sel1;
                    cmd_n   = cmd_in;
                    gnt_n   = sel1 ? 2'b10 : 2'b01;
                    if (is_legal(cmd_in.size, cmd_in.a)) begin
                        state_n  = ISSUE;
                        mreq_n   = 1'b1;
                        mwe_n    = cmd_in.we;
                        mbytes_n = bytes_of(cmd_in.size, cmd_in.a);
                        mad_n    = ad_in;
                        mwd_n    = wd_in;
                    end else begin
                        // rejected before the memory ever sees it
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (MGNT) begin
                    mreq_n = 1'b0;
                    // a memory that completes in its grant cycle skips WAIT
                    if (MERR) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end else if (MVALID) begin
                        done = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt_q + 8'd1;
                if (MERR) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (MVALID) begin
                    done = 1'b1;
                end else if (cnt_n == TO) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase

        // the response pulse is registered, so it is visible in RESP
        if (done) begin
            state_n = RESP;
            done_rd = (done_err | cmd_n.we) ? 32'd0
                                            : extract(MRD, cmd_n.size, cmd_n.uns, cmd_n.a);
            if (owner_n) begin
                vld_n[1] = ~done_err;
                err_n[1] = done_err;
                rd1_n    = done_rd;
            end else begin
                vld_n[0] = ~done_err;
                err_n[0] = done_err;
                rd0_n    = done_rd;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            rr_q     <= 1'b1;
            owner_q  <= 1'b0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            mbytes_q <= '0;
            mad_q    <= '0;
            mwd_q    <= '0;
        end else begin
            state_q  <= state_n;
            rr_q     <= rr_n;
            owner_q  <= owner_n;
            cmd_q    <= cmd_n;
            cnt_q    <= cnt_n;
            gnt_q    <= gnt_n;
            vld_q    <= vld_n;
            err_q    <= err_n;
            rd0_q    <= rd0_n;
            rd1_q    <= rd1_n;
            mreq_q   <= mreq_n;
            mwe_q    <= mwe_n;
            mbytes_q <= mbytes_n;
            mad_q    <= mad_n;
            mwd_q    <= mwd_n;
        end
    end

    assign GNT0   = gnt_q[0];
    assign GNT1   = gnt_q[1];
    assign VALID0 = vld_q[0];
    assign VALID1 = vld_q[1];
    assign ERR0   = err_q[0];
    assign ERR1   = err_q[1];
    assign RD0    = rd0_q;
    assign RD1    = rd1_q;
    assign MREQ   = mreq_q;
    assign MWE    = mwe_q;
    assign MBYTES = mbytes_q;
    assign MAD    = mad_q;
    assign MWD    = mwd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases, randomized rounds against a
// transaction-level model (round-robin pick, alignment, byte enables,
// extension arithmetic, expected response latency), and reset mid-WAIT.
module tb_mem_port_arbiter;
    localparam int TO = 16;

    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic        REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0, UNS0 = 0, UNS1 = 0;
    logic [1:0]  SIZE0 = 0, SIZE1 = 0;
    logic [31:0] AD0 = 0, AD1 = 0, WD0 = 0, WD1 = 0;
    logic        GNT0, GNT1, VALID0, VALID1, ERR0, ERR1;
    logic [31:0] RD0, RD1;
    logic        MREQ, MWE;
    logic [3:0]  MBYTES;
    logic [31:0] MAD, MWD;
    logic        MGNT = 0, MVALID = 0, MERR = 0;
    logic [31:0] MRD = 0;

    mem_port_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .SIZE0(SIZE0), .SIZE1(SIZE1), .UNS0(UNS0), .UNS1(UNS1),
        .AD0(AD0), .AD1(AD1), .WD0(WD0), .WD1(WD1),
        .GNT0(GNT0), .GNT1(GNT1), .VALID0(VALID0), .VALID1(VALID1),
        .ERR0(ERR0), .ERR1(ERR1), .RD0(RD0), .RD1(RD1),
        .MREQ(MREQ), .MWE(MWE), .MBYTES(MBYTES), .MAD(MAD), .MWD(MWD),
        .MGNT(MGNT), .MVALID(MVALID), .MERR(MERR), .MRD(MRD)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model state: pending command per requester, last winner, held RD
    logic        pend [2];
    logic        m_we [2];
    logic [1:0]  m_size [2];
    logic        m_uns [2];
    logic [31:0] m_ad [2], m_wd [2];
    logic [31:0] rd_hold [2];
    int          rr;
    // memory behaviour for the next transaction
    int          gd, outc, w;   // outc: 0 ok, 1 merr, 2 merr+mvalid, 3 timeout
    bit          fast;
    logic [31:0] mrd_v;

    task automatic drive_reqs();
        REQ0 = pend[0]; WE0 = m_we[0]; SIZE0 = m_size[0]; UNS0 = m_uns[0]; AD0 = m_ad[0]; WD0 = m_wd[0];
        REQ1 = pend[1]; WE1 = m_we[1]; SIZE1 = m_size[1]; UNS1 = m_uns[1]; AD1 = m_ad[1]; WD1 = m_wd[1];
    endtask

    task automatic set_cmd(input int x, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] ad, input logic [31:0] wd);
        pend[x] = 1'b1; m_we[x] = we; m_size[x] = size; m_uns[x] = uns; m_ad[x] = ad; m_wd[x] = wd;
    endtask

    task automatic set_mem(input int g, input bit f, input int o, input int ww, input logic [31:0] d);
        gd = g; fast = f; outc = o; w = ww; mrd_v = d;
    endtask

    task automatic rand_cmd(input int x);
        int sz;
        logic [31:0] a;
        sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
        a  = $urandom;
        if (sz != 3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        set_cmd(x, 1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic rand_mem();
        int r;
        r = $urandom_range(0, 9);
        set_mem($urandom_range(0, 3), $urandom_range(0, 4) == 0,
                (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3, $urandom_range(1, TO), $urandom);
        if (fast) outc = 0;
    endtask

    // One transaction: requests are already driven; lat = negedges until GNT.
    task automatic run_round(input int lat);
        int win, sz, a, got, resp_c, exp_rc;
        logic legal, e, hit, seq_bad, gnt_bad;
        logic [3:0] eb;
        logic [31:0] lane, v;

        win = (pend[0] && pend[1]) ? ((rr == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
        rr  = win;
        got = -1;
        for (int i = 1; i <= lat + 2 && got < 0; i++) begin
            @(negedge CLK);
            if (GNT0 | GNT1) got = i;
        end
        chk("gnt_lat", got, lat);
        chk("gnt_who", {GNT1, GNT0}, (win == 1) ? 2'b10 : 2'b01);

        sz    = m_size[win];
        a     = m_ad[win] % 4;
        legal = (sz != 3) && (m_ad[win] % (32'd1 << sz) == 0);
        eb    = 4'(((1 << (1 << sz)) - 1) << a);
        e     = !legal || (!fast && outc != 0);
        exp_rc = !legal ? 0 : fast ? gd + 1 : (outc == 3) ? gd + 1 + TO : gd + 1 + w;
        v = 32'd0;
        if (!e && !m_we[win]) begin
            lane = mrd_v >> (8 * a);
            if (sz == 0) begin
                v = lane % 256;
                if (!m_uns[win] && v >= 128) v = v + 32'hFFFF_FF00;
            end else if (sz == 1) begin
                v = lane % 65536;
                if (!m_uns[win] && v >= 32768) v = v + 32'hFFFF_0000;
            end else v = mrd_v;
        end

        pend[win] = 1'b0;
        drive_reqs();

        if (legal) begin
            chk("mem_req", {MREQ, MWE, MBYTES}, {1'b1, m_we[win], eb});
            chk("mem_ad_wd", {MAD, MWD}, {m_ad[win], m_wd[win]});
        end else
            chk("mreq_rejected", MREQ, 1'b0);

        resp_c  = (VALID0 | VALID1 | ERR0 | ERR1) ? 0 : -1;
        seq_bad = 1'b0;
        gnt_bad = 1'b0;
        for (int c = 1; c <= exp_rc + 3 && resp_c < 0; c++) begin
            hit    = (fast && c == gd + 1) || (!fast && outc != 3 && c == gd + 1 + w);
            MGNT   = (c == gd + 1);
            MVALID = hit && (outc == 0 || outc == 2);
            MERR   = hit && (outc == 1 || outc == 2);
            MRD    = hit ? mrd_v : $urandom;
            @(negedge CLK);
            if (MREQ !== (c <= gd)) seq_bad = 1'b1;
            if (c <= gd && {MWE, MBYTES, MAD, MWD} !== {m_we[win], eb, m_ad[win], m_wd[win]}) seq_bad = 1'b1;
            if (GNT0 | GNT1) gnt_bad = 1'b1;
            if (VALID0 | VALID1 | ERR0 | ERR1) resp_c = c;
        end
        MGNT = 0; MVALID = 0; MERR = 0;
        if (legal) chk("mreq_seq", seq_bad, 1'b0);
        chk("gnt_once", gnt_bad, 1'b0);
        chk("resp_lat", resp_c, exp_rc);
        chk("resp_bits", {VALID1, VALID0, ERR1, ERR0},
            (win == 1) ? {!e, 1'b0, e, 1'b0} : {1'b0, !e, 1'b0, e});
        rd_hold[win] = v;
        chk("rd", {RD1, RD0}, {rd_hold[1], rd_hold[0]});
    endtask

    initial begin
        for (int x = 0; x < 2; x++) begin
            pend[x] = 0; m_we[x] = 0; m_size[x] = 0; m_uns[x] = 0; m_ad[x] = 0; m_wd[x] = 0; rd_hold[x] = 0;
        end
        rr = 1;
        repeat (3) @(negedge CLK);
        chk("rst_ctl", {GNT1, GNT0, VALID1, VALID0, ERR1, ERR0, MREQ, MWE, MBYTES}, 0);
        chk("rst_rd", {RD1, RD0}, 0);
        chk("rst_mem", {MAD, MWD}, 0);

        RESET_N = 1'b1;
        // directed cases
        set_cmd(0, 0, 2'b10, 0, 32'h10, 32'h0); set_mem(1, 0, 0, 2, 32'hDEADBEEF);
        drive_reqs(); run_round(1);
        set_cmd(1, 1, 2'b00, 0, 32'h13, 32'hAB); set_mem(2, 0, 0, 1, 32'h0);
        drive_reqs(); run_round(2);
        set_cmd(0, 0, 2'b00, 0, 32'h21, 32'h0); set_mem(0, 1, 0, 1, 32'h0000F200);
        drive_reqs(); run_round(2);
        set_cmd(1, 0, 2'b00, 1, 32'h21, 32'h0); set_mem(0, 0, 0, 3, 32'h0000F200);
        drive_reqs(); run_round(2);
        set_cmd(0, 0, 2'b01, 0, 32'h22, 32'h0); set_mem(1, 0, 0, 1, 32'h80010000);
        drive_reqs(); run_round(2);
        set_cmd(0, 0, 2'b10, 0, 32'h06, 32'h0); set_mem(0, 0, 0, 1, 32'h0);
        drive_reqs(); run_round(2);
        set_cmd(1, 1, 2'b11, 0, 32'h40, 32'h5); set_mem(0, 0, 0, 1, 32'h0);
        drive_reqs(); run_round(2);
        set_cmd(0, 0, 2'b10, 0, 32'h80, 32'h0); set_mem(0, 0, 1, 3, 32'h1234);
        drive_reqs(); run_round(2);
        set_cmd(1, 0, 2'b10, 0, 32'h84, 32'h0); set_mem(1, 0, 3, 1, 32'h0);
        drive_reqs(); run_round(2);
        set_cmd(0, 0, 2'b10, 0, 32'h88, 32'h0); set_mem(0, 0, 2, TO, 32'h77);
        drive_reqs(); run_round(2);
        set_cmd(1, 0, 2'b10, 0, 32'h8C, 32'h0); set_mem(0, 0, 0, TO, 32'hCAFEF00D);
        drive_reqs(); run_round(2);

        // randomized rounds
        for (int r = 0; r < 120; r++) begin
            for (int x = 0; x < 2; x++)
                if (!pend[x] && $urandom_range(0, 2) != 0) rand_cmd(x);
            if (!pend[0] && !pend[1]) rand_cmd(0);
            rand_mem();
            drive_reqs();
            run_round(2);
        end

        // reset in the middle of WAIT
        pend[0] = 0; pend[1] = 0;
        set_cmd(0, 0, 2'b10, 0, 32'h40, 32'h0);
        drive_reqs();
        repeat (2) @(negedge CLK);
        chk("mw_gnt", {GNT1, GNT0}, 2'b01);
        pend[0] = 0; drive_reqs();
        MGNT = 1;
        @(negedge CLK);
        MGNT = 0;
        chk("mw_in_wait", MREQ, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("mw_rst_ctl", {GNT1, GNT0, VALID1, VALID0, ERR1, ERR0, MREQ, MWE, MBYTES}, 0);
        chk("mw_rst_data", {RD1, RD0, MAD, MWD}, 0);
        rd_hold[0] = 0; rd_hold[1] = 0; rr = 1;

        // both requesting continuously: grants alternate starting with M0
        RESET_N = 1'b1;
        rand_cmd(0); rand_cmd(1); rand_mem();
        drive_reqs(); run_round(1);
        for (int r = 0; r < 5; r++) begin
            if (!pend[0]) rand_cmd(0);
            if (!pend[1]) rand_cmd(1);
            rand_mem();
            drive_reqs();
            run_round(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
